vga_scan_timing: RTL
====================

# vga_scan_timing

Raster scan generator and pixel output stage that sits on the other side of the sprite/colour compositor. It produces the DrawX/DrawY scan coordinates the compositor consumes. It registers the compositor's combinational Red/Green/Blue result into blanked, sync-aligned VGA outputs. It also provides the frame and vertical-blank strobes that game logic uses to update object positions.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines (V_TOTAL = 525)
- CLK_DIV, 4, Clk cycles per pixel (≥1)

Ports:
- Clk  in  1  system clock; one clock domain only
- Reset  in  1  asynchronous, active-high reset
- Red_In, Green_In, Blue_In  in  4 each  compositor colour for the current DrawX/DrawY
- DrawX  out  10  horizontal counter hc, range 0..H_TOTAL-1
- DrawY  out  10  vertical counter vc, range 0..V_TOTAL-1
- PixEn  out  1  one-Clk pixel strobe
- FrameStart  out  1  one-Clk pulse at end of frame
- VBlank  out  1  high while vc ≥ V_ACTIVE
- HS, VS  out  1 each  sync outputs, active-low
- Red, Green, Blue  out  4 each  registered, blanked pixel colour

## Operation
- Divider:
  - div_cnt counts 0..CLK_DIV-1, free-running, then wraps.
  - PixEn = (div_cnt == CLK_DIV-1). With CLK_DIV=1, PixEn is constantly 1.
- Scan counters advance only on PixEn:
  - hc increments; at H_TOTAL-1 it wraps to 0 and vc increments.
  - When vc is at V_TOTAL-1 and hc wraps, vc wraps to 0.
  - DrawX = hc and DrawY = vc directly, as raw registers with no offset.
- Output stage updates only on PixEn, using the current hc/vc and Red_In/Green_In/Blue_In:
  - Red/Green/Blue ← *_In when hc < H_ACTIVE and vc < V_ACTIVE; otherwise 0.
  - HS ← 0 when H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise 1.
  - VS ← 0 when V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise 1.
- FrameStart = PixEn & (hc == H_TOTAL-1) & (vc == V_TOTAL-1). It is asserted in the Clk cycle before the counters wrap to (0,0).
- VBlank is decoded from the vc register. It is high for lines 480..524.
- Width rules:
  - Comparisons are 10-bit unsigned.
  - Parameter sums must stay below 1024.
  - div_cnt width is $clog2(CLK_DIV), with a minimum of 1 bit.
- Reset (asynchronous, takes effect immediately):
  - div_cnt=0, hc=0, vc=0.
  - HS=1, VS=1, Red=Green=Blue=0, FrameStart=0.
  - PixEn=(CLK_DIV==1).
  - Reset asserted mid-line or mid-frame abandons the frame. Scanning restarts at (0,0) with no partial sync pulse carried over.

## Timing
- After Reset deasserts, PixEn first rises when div_cnt reaches CLK_DIV-1, i.e. after CLK_DIV-1 Clk edges. At that edge hc steps to 1.
- Pixel period is CLK_DIV Clk cycles.
- Line is H_TOTAL PixEn strobes (800).
- Frame is H_TOTAL·V_TOTAL·CLK_DIV Clk cycles (1,680,000 at the defaults).
- Pipeline latency is one pixel:
  - Red/Green/Blue/HS/VS reflect the DrawX/DrawY value present on the previous PixEn.
  - The three colour outputs and both syncs are mutually aligned.
- Compositor path: Red_In/Green_In/Blue_In must be a combinational function of DrawX/DrawY. They must settle within CLK_DIV Clk cycles.
- HS low width is 96 pixels. VS low width is 2 full lines (1600 pixels). VS transitions coincide with HS-independent line starts, i.e. on the PixEn where hc wraps to 0.
- FrameStart and VBlank are valid on Clk. Consumers sample them on any Clk edge.

## Test plan
- Reset mid-line:
  - Assert Reset at hc=300, vc=100 → outputs go to reset values without waiting for Clk.
  - After release: DrawX=0, DrawY=0; first PixEn 3 Clk later (CLK_DIV=4); DrawX=1 after that edge.
- Horizontal timing → 800 PixEn between successive HS falling edges; HS low for exactly 96 PixEn; HS falls on the PixEn following the one where DrawX=656.
- Vertical timing → VS low for exactly 1600 PixEn, covering lines 490–491; 525 lines between VS falling edges; VBlank high for 45 lines (480–524).
- Blanking:
  - Drive Red_In=Green_In=Blue_In=4'hF constantly → outputs are F for exactly 640 pixels per line and 480 lines per frame, 0 elsewhere.
  - The first F appears one pixel after DrawX=0, DrawY=0.
- Pipeline alignment: Red_In=DrawX[3:0] → on every active pixel, Red equals the previous DrawX[3:0]; HS edges stay aligned with the colour stream.
- Frame strobe → FrameStart exactly one Clk wide, once per 1,680,000 Clk cycles, coincident with DrawX=799, DrawY=524, PixEn=1. Repeat with CLK_DIV=1 → PixEn constantly 1 and frame = 420,000 Clk cycles.

Source files
------------

// File: rtl/vga_scan_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_scan_timing
// Brief    : Raster scan counters plus blanked, sync-aligned RGB output stage.
// Revision : 1.0
// ============================================================================
module vga_scan_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Red_In,
    input  logic [3:0] Green_In,
    input  logic [3:0] Blue_In,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       PixEn,
    output logic       FrameStart,
    output logic       VBlank,
    output logic       HS,
    output logic       VS,
    output logic [3:0] Red,
    output logic [3:0] Green,
    output logic [3:0] Blue
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] c_h_last     = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last     = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_active   = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_active   = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_end     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_end     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    logic [c_div_w-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]         hc_q, hc_d;
    logic [9:0]         vc_q, vc_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic [3:0]         red_q, red_d;
    logic [3:0]         green_q, green_d;
    logic [3:0]         blue_q, blue_d;

    logic w_pix_en;
    logic w_active;
    logic w_hsync_win;
    logic w_vsync_win;
    logic w_h_wrap;

    // With CLK_DIV == 1 the counter sits at zero, which equals c_div_last,
    // so the strobe is permanently high without a special case.
    assign w_pix_en    = (div_cnt_q == c_div_last);
    assign w_h_wrap    = (hc_q == c_h_last);
    assign w_active    = (hc_q < c_h_active) && (vc_q < c_v_active);
    assign w_hsync_win = (hc_q >= c_hs_start) && (hc_q < c_hs_end);
    assign w_vsync_win = (vc_q >= c_vs_start) && (vc_q < c_vs_end);

    always_comb begin
        div_cnt_d = w_pix_en ? '0 : div_cnt_q + 1'b1;
        hc_d      = hc_q;
        vc_d      = vc_q;
        if (w_pix_en) begin
            if (w_h_wrap) begin
                hc_d = '0;
                vc_d = (vc_q == c_v_last) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // Output stage samples the pixel currently addressed by hc/vc, giving a
    // one-pixel latency that is identical for colour and both syncs.
    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        if (w_pix_en) begin
            hs_d    = ~w_hsync_win;
            vs_d    = ~w_vsync_win;
            red_d   = w_active ? Red_In   : 4'h0;
            green_d = w_active ? Green_In : 4'h0;
            blue_d  = w_active ? Blue_In  : 4'h0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt_q <= '0;
            hc_q      <= '0;
            vc_q      <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign DrawX      = hc_q;
    assign DrawY      = vc_q;
    assign PixEn      = w_pix_en;
    assign FrameStart = w_pix_en & w_h_wrap & (vc_q == c_v_last);
    assign VBlank     = (vc_q >= c_v_active);
    assign HS         = hs_q;
    assign VS         = vs_q;
    assign Red        = red_q;
    assign Green      = green_q;
    assign Blue       = blue_q;

endmodule
`default_nettype wire
